// File: rtl/tim_apb_pkg.sv
// Shared definitions for the timer APB arbiter: FSM states, register map, default widths.
package tim_apb_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  localparam logic [11:0] TCR   = 12'h000;
  localparam logic [11:0] TDR0  = 12'h004;
  localparam logic [11:0] TDR1  = 12'h008;
  localparam logic [11:0] TCMP0 = 12'h00C;
  localparam logic [11:0] TCMP1 = 12'h010;
  localparam logic [11:0] TIER  = 12'h014;
  localparam logic [11:0] TISR  = 12'h018;
  localparam logic [11:0] THCSR = 12'h01C;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_ACCESS   = 2'd2,
    ST_COMPLETE = 2'd3
  } arb_state_e;

  // Width of a counter that must be able to hold the value 'limit'; never zero.
  function automatic int cnt_width(input int limit);
    return (limit <= 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/tim_rr_arb2.sv
// Two-input round-robin grant; the remembered winner only moves when the arbiter is enabled.
module tim_rr_arb2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt_vld,
  output logic o_gnt_idx
);

  logic r_last_grant;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    o_gnt_vld = i_req0 | i_req1;
    o_gnt_idx = (i_req0 & i_req1) ? ~r_last_grant : i_req1;
  end

  // Reset to m1 so that m0 wins the very first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= 1'b1;
    end else if (i_en && o_gnt_vld) begin
      r_last_grant <= o_gnt_idx;
    end
  end

endmodule

// File: rtl/tim_apb_arb.sv
// Shares the timer's APB slave port between two requesters with round-robin grant,
// SETUP/ACCESS sequencing and an optional ACCESS-phase timeout.
module tim_apb_arb
  import tim_apb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,

  input  logic                m0_req,
  input  logic                m0_write,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_strb,
  output logic                m0_done,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_err,

  input  logic                m1_req,
  input  logic                m1_write,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_strb,
  output logic                m1_done,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,

  output logic                tim_psel,
  output logic                tim_penable,
  output logic                tim_pwrite,
  output logic [ADDR_W-1:0]   tim_paddr,
  output logic [DATA_W-1:0]   tim_pwdata,
  output logic [DATA_W/8-1:0] tim_pstrb,
  input  logic [DATA_W-1:0]   tim_prdata,
  input  logic                tim_pready,
  input  logic                tim_pslverr,

  output logic                arb_busy,
  output logic [1:0]          dbg_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC);

  // Requester handshake: mN_req is held with its fields stable until the cycle
  // mN_done=1; fields may change on the edge that samples done, and a req still
  // high in the following IDLE cycle starts a new transfer.

  arb_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_owner;
  logic                r_busy;

  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [STRB_W-1:0]   r_pstrb;

  logic                r_m0_done;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic                r_m0_err;
  logic                r_m1_done;
  logic [DATA_W-1:0]   r_m1_rdata;
  logic                r_m1_err;

  logic                w_arb_en;
  logic                w_gnt_vld;
  logic                w_gnt_idx;
  logic                w_sel_write;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [STRB_W-1:0]   w_sel_strb;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_timeout;
  logic                w_fin;
  logic [DATA_W-1:0]   w_fin_rdata;
  logic                w_fin_err;

  assign w_arb_en = (r_state == ST_IDLE);

  tim_rr_arb2 u_rr (
    .i_clk     (sys_clk),
    .i_rst_n   (sys_rst_n),
    .i_en      (w_arb_en),
    .i_req0    (m0_req),
    .i_req1    (m1_req),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_idx (w_gnt_idx)
  );

  always_comb begin
    w_sel_write = w_gnt_idx ? m1_write : m0_write;
    w_sel_addr  = w_gnt_idx ? m1_addr  : m0_addr;
    w_sel_wdata = w_gnt_idx ? m1_wdata : m0_wdata;
    w_sel_strb  = w_gnt_idx ? m1_strb  : m0_strb;
  end

  // The counter saturates; the limit check uses the post-increment value so an
  // abort happens on exactly the TIMEOUT_CYC-th ACCESS cycle without pready.
  always_comb begin
    w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    w_timeout   = (TIMEOUT_CYC != 0) && (w_cnt_inc == CNT_LIM);
    w_fin       = tim_pready || w_timeout;
    w_fin_rdata = '0;
    w_fin_err   = 1'b1;
    if (tim_pready) begin
      w_fin_rdata = r_pwrite ? '0 : tim_prdata;
      w_fin_err   = tim_pslverr;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_owner    <= 1'b0;
      r_busy     <= 1'b0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_pstrb    <= '0;
      r_m0_done  <= 1'b0;
      r_m0_rdata <= '0;
      r_m0_err   <= 1'b0;
      r_m1_done  <= 1'b0;
      r_m1_rdata <= '0;
      r_m1_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_gnt_vld) begin
            r_owner  <= w_gnt_idx;
            r_pwrite <= w_sel_write;
            r_paddr  <= w_sel_addr;
            r_pwdata <= w_sel_wdata;
            r_pstrb  <= w_sel_write ? w_sel_strb : '0;
            r_psel   <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (!tim_pready) begin
            r_cnt <= w_cnt_inc;
          end
          if (w_fin) begin
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_pstrb    <= '0;
            r_m0_done  <= ~r_owner;
            r_m0_rdata <= r_owner ? '0 : w_fin_rdata;
            r_m0_err   <= ~r_owner & w_fin_err;
            r_m1_done  <= r_owner;
            r_m1_rdata <= r_owner ? w_fin_rdata : '0;
            r_m1_err   <= r_owner & w_fin_err;
            r_state    <= ST_COMPLETE;
          end
        end

        ST_COMPLETE: begin
          r_m0_done  <= 1'b0;
          r_m0_rdata <= '0;
          r_m0_err   <= 1'b0;
          r_m1_done  <= 1'b0;
          r_m1_rdata <= '0;
          r_m1_err   <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tim_psel    = r_psel;
  assign tim_penable = r_penable;
  assign tim_pwrite  = r_pwrite;
  assign tim_paddr   = r_paddr;
  assign tim_pwdata  = r_pwdata;
  assign tim_pstrb   = r_pstrb;

  assign m0_done  = r_m0_done;
  assign m0_rdata = r_m0_rdata;
  assign m0_err   = r_m0_err;
  assign m1_done  = r_m1_done;
  assign m1_rdata = r_m1_rdata;
  assign m1_err   = r_m1_err;

  assign arb_busy  = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tim_apb_arb.sv
// Bench for tim_apb_arb: transfer-timeline model with a slave memory, directed scenarios,
// randomized traffic, and per-cycle comparison of every DUT output.
module tb_tim_apb_arb;
  import tim_apb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            wt;   // pready-low cycles the slave inserts for this transfer
  } xfer_t;

  // ---------------- clock / reset / DUT ----------------
  logic          sys_clk;
  logic          sys_rst_n;
  logic          m0_req, m0_write, m0_done, m0_err;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic [SW-1:0] m0_strb;
  logic          m1_req, m1_write, m1_done, m1_err;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [SW-1:0] m1_strb;
  logic          tim_psel, tim_penable, tim_pwrite, tim_pready, tim_pslverr;
  logic [AW-1:0] tim_paddr;
  logic [DW-1:0] tim_pwdata, tim_prdata;
  logic [SW-1:0] tim_pstrb;
  logic          arb_busy;
  logic [1:0]    dbg_state;

  tim_apb_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_strb(m0_strb), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_strb(m1_strb), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_prdata(tim_prdata), .tim_pready(tim_pready), .tim_pslverr(tim_pslverr),
    .arb_busy(arb_busy), .dbg_state(dbg_state)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- bench state ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;
  bit rnd_on  = 0;

  logic [DW:0] exp_q[$];          // {err, rdata} per granted transfer
  xfer_t       q0[$], q1[$];      // pending transfers per requester
  xfer_t       cur0, cur1;
  bit          act[2];
  bit          req_lvl[2];
  int          start_cyc[2], done_cyc[2];
  logic [DW-1:0] obs_rdata[2];
  logic        obs_err[2];
  int          done_order[$];
  logic [DW-1:0] mem[8];

  // Current transfer as a timeline: t=1 SETUP, t=2..1+acc_len ACCESS, t=2+acc_len done.
  bit          busy;
  int          t, acc_len, own, last_g;
  xfer_t       tx;
  logic [DW-1:0] rsp_prdata;
  logic        rsp_err, rsp_to;

  function automatic xfer_t mk(input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                               input int wt);
    xfer_t x;
    x.wr = wr; x.addr = addr; x.wdata = wdata; x.strb = strb; x.wt = wt;
    return x;
  endfunction

  function automatic xfer_t rnd_xfer();
    xfer_t x;
    int k;
    x.wr    = 1'($urandom_range(0, 1));
    k       = int'($urandom_range(0, 19));
    x.addr  = (k == 0) ? 12'h1F4 :
              (k == 1) ? AW'($urandom_range(8, 1023) << 2) :
                         AW'($urandom_range(0, 7) << 2);
    x.wdata = $urandom;
    x.strb  = SW'($urandom_range(0, 15));
    k       = int'($urandom_range(0, 39));
    x.wt    = (k == 0) ? int'($urandom_range(16, 20)) :
              (k == 1) ? 15 : int'($urandom_range(0, 3));
    return x;
  endfunction

  task automatic cmp(input string name, input logic [127:0] act_v, input logic [127:0] exp_v);
    vec_cnt++;
    if (act_v !== exp_v) begin
      err_cnt++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act_v, exp_v);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  task automatic check_cycle();
    logic          e_psel, e_pen;
    logic [50:0]   e_bus;
    logic [DW+1:0] e_m0, e_m1;
    logic [DW:0]   rsp;
    e_psel = busy && t >= 1 && t <= 1 + acc_len;
    e_pen  = busy && t >= 2 && t <= 1 + acc_len;
    e_bus  = e_psel ? {1'b1, e_pen, tx.wr, tx.addr, tx.wdata, (tx.wr ? tx.strb : 4'h0)} : '0;
    e_m0   = '0;
    e_m1   = '0;
    if (busy && t == 2 + acc_len) begin
      if (exp_q.size() == 0) begin
        vec_cnt++; err_cnt++;
        $display("FAIL scoreboard_empty cyc=%0d got=none expected=entry", cyc);
      end else begin
        rsp = exp_q.pop_front();
        if (own == 0) e_m0 = {1'b1, rsp};
        else          e_m1 = {1'b1, rsp};
      end
    end
    cmp("bus", {tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb}, e_bus);
    cmp("m0",  {m0_done, m0_err, m0_rdata}, e_m0);
    cmp("m1",  {m1_done, m1_err, m1_rdata}, e_m1);
    cmp("busy", {arb_busy, (dbg_state == ST_IDLE)}, {busy, !busy});
    if (m0_done) begin
      obs_rdata[0] = m0_rdata; obs_err[0] = m0_err; done_cyc[0] = cyc; done_order.push_back(0);
    end
    if (m1_done) begin
      obs_rdata[1] = m1_rdata; obs_err[1] = m1_err; done_cyc[1] = cyc; done_order.push_back(1);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_inputs();
    if (!act[0] && q0.size() > 0) begin
      cur0 = q0.pop_front(); act[0] = 1; req_lvl[0] = 1; start_cyc[0] = cyc;
    end
    if (!act[1] && q1.size() > 0) begin
      cur1 = q1.pop_front(); act[1] = 1; req_lvl[1] = 1; start_cyc[1] = cyc;
    end
    // A granted requester may let go of req; the transfer must still finish.
    if (rnd_on && busy && act[own] && $urandom_range(0, 3) == 0) req_lvl[own] = 0;

    m0_req = req_lvl[0]; m0_write = cur0.wr; m0_addr = cur0.addr;
    m0_wdata = cur0.wdata; m0_strb = cur0.strb;
    m1_req = req_lvl[1]; m1_write = cur1.wr; m1_addr = cur1.addr;
    m1_wdata = cur1.wdata; m1_strb = cur1.strb;

    if (busy && t >= 2 && t <= 1 + acc_len) begin
      tim_pready  = !rsp_to && (t - 1 == tx.wt + 1);
      tim_prdata  = tim_pready ? rsp_prdata : $urandom;
      tim_pslverr = tim_pready ? rsp_err : 1'($urandom_range(0, 1));
    end else begin
      tim_pready  = 1'($urandom_range(0, 1));
      tim_prdata  = $urandom;
      tim_pslverr = 1'($urandom_range(0, 1));
    end
  endtask

  // ---------------- reference model ----------------
  task automatic advance();
    bit bad;
    if (!busy) begin
      if (req_lvl[0] || req_lvl[1]) begin
        own     = (req_lvl[0] && req_lvl[1]) ? 1 - last_g : (req_lvl[1] ? 1 : 0);
        last_g  = own;
        tx      = (own == 0) ? cur0 : cur1;
        bad     = tx.addr > 12'h01C;
        rsp_to  = (TO != 0) && (tx.wt >= TO);
        acc_len = rsp_to ? TO : tx.wt + 1;
        rsp_prdata = (tx.wr || bad) ? $urandom : mem[tx.addr[4:2]];
        rsp_err = bad;
        if (rsp_to) exp_q.push_back({1'b1, {DW{1'b0}}});
        else        exp_q.push_back({rsp_err, (tx.wr ? {DW{1'b0}} : rsp_prdata)});
        if (tx.wr && !bad && !rsp_to)
          for (int b = 0; b < SW; b++)
            if (tx.strb[b]) mem[tx.addr[4:2]][8*b +: 8] = tx.wdata[8*b +: 8];
        busy = 1; t = 1;
      end
    end else if (t == 2 + acc_len) begin
      busy = 0; act[own] = 0; req_lvl[own] = 0;
    end else begin
      t++;
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
    cyc++;
    check_cycle();
    drive_inputs();
    advance();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || act[0] || act[1] || busy) && n < budget) begin
      step();
      n++;
    end
    step();
    if (n >= budget) begin
      err_cnt++;
      $display("FAIL drain_timeout cyc=%0d got=%0d cycles expected=<%0d", cyc, n, budget);
    end
  endtask

  task automatic zero_inputs();
    m0_req = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0; m0_strb = '0;
    m1_req = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0; m1_strb = '0;
    tim_prdata = '0; tim_pready = 0; tim_pslverr = 0;
  endtask

  task automatic model_reset();
    busy = 0; t = 0; acc_len = 0; own = 0; last_g = 1;
    act[0] = 0; act[1] = 0; req_lvl[0] = 0; req_lvl[1] = 0;
    exp_q.delete();
    cur0 = mk(0, '0, '0, '0, 0); cur1 = mk(0, '0, '0, '0, 0);
  endtask

  task automatic check_all_zero(input string name);
    cmp({name, "_bus"}, {tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb}, '0);
    cmp({name, "_req"}, {m0_done, m0_err, m0_rdata, m1_done, m1_err, m1_rdata}, '0);
    cmp({name, "_busy"}, {arb_busy, dbg_state}, '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] ord;
    sys_rst_n = 0;
    zero_inputs();
    model_reset();
    for (int i = 0; i < 8; i++) mem[i] = '0;
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");
    sys_rst_n = 1;

    // Simultaneous requests right after reset, then alternating ties.
    done_order.delete();
    q0.push_back(mk(1, TCMP0, 32'h1111_1111, 4'hF, 0));
    q1.push_back(mk(1, TCMP1, 32'h2222_2222, 4'hF, 0));
    q0.push_back(mk(0, TCMP1, 32'h0, 4'hF, 0));
    q1.push_back(mk(0, TCMP0, 32'h0, 4'hF, 0));
    drain(200);
    ord = '1;
    for (int i = 0; i < 4 && i < done_order.size(); i++) ord[3 - i] = done_order[i][0];
    cmp("tie_order", {28'(done_order.size()), ord}, {28'd4, 4'b0101});
    cmp("tie_rd_m0", obs_rdata[0], 32'h2222_2222);
    cmp("tie_rd_m1", obs_rdata[1], 32'h1111_1111);

    // Single write without wait states, then read back.
    q0.push_back(mk(1, TCMP0, 32'h1234_5678, 4'hF, 0));
    drain(100);
    cmp("wr_lat", done_cyc[0] - start_cyc[0], 3);
    cmp("wr_err", obs_err[0], 1'b0);
    q0.push_back(mk(0, TCMP0, 32'h0, 4'h0, 0));
    drain(100);
    cmp("rd_data", obs_rdata[0], 32'h1234_5678);

    // Three wait states on a read.
    q0.push_back(mk(0, TDR0, 32'hDEAD_BEEF, 4'hF, 3));
    drain(100);
    cmp("wait_lat", done_cyc[0] - start_cyc[0], 6);

    // Timeout on m1 with m0 pending behind it.
    done_order.delete();
    q1.push_back(mk(0, TDR1, 32'h0, 4'h0, 40));
    repeat (3) step();
    q0.push_back(mk(1, TCR, 32'h0000_00A5, 4'h1, 1));
    drain(200);
    cmp("to_m1", {obs_err[1], obs_rdata[1]}, {1'b1, 32'h0});
    cmp("to_lat", done_cyc[1] - start_cyc[1], 18);
    cmp("to_m0_err", obs_err[0], 1'b0);
    cmp("to_order", done_order[0], 1);

    // pready on the same cycle as the limit: normal completion.
    q1.push_back(mk(0, TCR, 32'h0, 4'h0, 15));
    drain(200);
    cmp("edge_m1", {obs_err[1], obs_rdata[1]}, {1'b0, 32'h0000_00A5});
    cmp("edge_lat", done_cyc[1] - start_cyc[1], 18);

    // Slave error, then a clean transfer.
    q0.push_back(mk(1, 12'h1F4, 32'hCAFE_F00D, 4'hF, 0));
    drain(100);
    cmp("slverr", obs_err[0], 1'b1);
    q0.push_back(mk(1, TIER, 32'h0000_0005, 4'hF, 0));
    drain(100);
    cmp("slverr_next", obs_err[0], 1'b0);

    // Randomized traffic.
    rnd_on = 1;
    for (int c = 0; c < 3000; c++) begin
      if (q0.size() == 0 && $urandom_range(0, 3) == 0) q0.push_back(rnd_xfer());
      if (q1.size() == 0 && $urandom_range(0, 3) == 0) q1.push_back(rnd_xfer());
      step();
    end
    drain(500);
    rnd_on = 0;

    // Reset during an ACCESS wait state.
    q0.push_back(mk(0, TDR0, 32'h0, 4'h0, 10));
    repeat (3) step();
    sys_rst_n = 0;
    #1;
    check_all_zero("midrst");
    zero_inputs();
    model_reset();
    q0.delete(); q1.delete();
    repeat (2) @(negedge sys_clk);
    q1.push_back(mk(1, TCMP1, 32'h3333_3333, 4'hF, 0));
    q0.push_back(mk(1, TCMP0, 32'h4444_4444, 4'hF, 0));
    done_order.delete();
    sys_rst_n = 1;
    drain(100);
    cmp("rst_first", (done_order.size() > 0) ? done_order[0] : -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
